// File: rtl/tqvp_crc32_pkg.sv
// Shared constants, register map and state encoding for the tqvp_crc32 peripheral.
package tqvp_crc32_pkg;

    localparam logic [31:0] CRC_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    localparam logic [5:0] ADDR_DATA   = 6'h00;
    localparam logic [5:0] ADDR_CTRL   = 6'h04;
    localparam logic [5:0] ADDR_STATUS = 6'h08;
    localparam logic [5:0] ADDR_RAW    = 6'h0C;

    localparam logic [1:0] XFER_BYTE = 2'b00;
    localparam logic [1:0] XFER_HALF = 2'b01;
    localparam logic [1:0] XFER_WORD = 2'b10;
    localparam logic [1:0] XFER_NONE = 2'b11;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } state_t;

    // Number of data bits carried by a transfer of the given width encoding.
    function automatic int unsigned xfer_bits(input logic [1:0] width);
        case (width)
            XFER_BYTE: return 8;
            XFER_HALF: return 16;
            default:   return 32;
        endcase
    endfunction

endpackage

// File: rtl/tqvp_crc32_step.sv
// Combinational fold of BITS data bits (LSB first) into a reflected CRC-32 state.
module crc32_step
    import tqvp_crc32_pkg::*;
#(
    parameter int unsigned BITS = 1
) (
    input  logic [31:0]     crc_in,
    input  logic [BITS-1:0] data_bits,
    output logic [31:0]     crc_out
);

    always_comb begin
        logic [31:0] acc;
        acc = crc_in;
        for (int unsigned i = 0; i < BITS; i++) begin
            if (acc[0] ^ data_bits[i]) begin
                acc = (acc >> 1) ^ CRC_POLY;
            end else begin
                acc = acc >> 1;
            end
        end
        crc_out = acc;
    end

endmodule

// File: rtl/tqvp_crc32.sv
// TinyQV user peripheral: CRC-32 (IEEE 802.3) engine folding BITS_PER_CYCLE bits per clock,
// with a stalled read of DATA/RAW while a fold is in flight.
module tqvp_crc32
    import tqvp_crc32_pkg::*;
#(
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    state_t      state;
    logic [31:0] crc;
    logic [31:0] shreg;
    logic [5:0]  remaining;
    logic        done;
    logic        overrun;
    logic        irq_en;
    logic [31:0] crc_next;

    logic wr_en, rd_en, busy;
    logic data_wr, ctrl_wr, status_wr, init;
    logic unused_inputs;

    assign unused_inputs = &{1'b0, ui_in};

    always_comb begin
        wr_en     = (data_write_n != XFER_NONE);
        rd_en     = (data_read_n != XFER_NONE);
        busy      = (state == ST_SHIFT);
        data_wr   = wr_en && (address == ADDR_DATA);
        ctrl_wr   = wr_en && (address == ADDR_CTRL);
        status_wr = wr_en && (address == ADDR_STATUS);
        init      = ctrl_wr && data_in[0];
    end

    crc32_step #(.BITS(BITS_PER_CYCLE)) u_step (
        .crc_in    (crc),
        .data_bits (shreg[BITS_PER_CYCLE-1:0]),
        .crc_out   (crc_next)
    );

    // Completion is applied after the STATUS clear so a coincident clear loses,
    // and INIT is applied last so it overrides a completion in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            crc       <= CRC_INIT;
            shreg     <= '0;
            remaining <= '0;
            done      <= 1'b0;
            overrun   <= 1'b0;
            irq_en    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en <= data_in[1];
            end
            if (status_wr) begin
                if (data_in[1]) done    <= 1'b0;
                if (data_in[2]) overrun <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (data_wr) begin
                        shreg     <= data_in;
                        remaining <= 6'(xfer_bits(data_write_n) / BITS_PER_CYCLE);
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (data_wr) begin
                        overrun <= 1'b1;
                    end
                    crc       <= crc_next;
                    shreg     <= shreg >> BITS_PER_CYCLE;
                    remaining <= remaining - 6'd1;
                    if (remaining == 6'd1) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (init) begin
                state     <= ST_IDLE;
                crc       <= CRC_INIT;
                remaining <= '0;
                done      <= 1'b0;
                overrun   <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = '0;
        case (address)
            ADDR_DATA:   data_out = crc ^ CRC_XOROUT;
            ADDR_CTRL:   data_out = {30'b0, irq_en, 1'b0};
            ADDR_STATUS: data_out = {29'b0, overrun, done, busy};
            ADDR_RAW:    data_out = crc;
            default:     data_out = '0;
        endcase
    end

    assign data_ready     = !(rd_en && busy && ((address == ADDR_DATA) || (address == ADDR_RAW)));
    assign uo_out         = {6'b0, done, busy};
    assign user_interrupt = done & irq_en;

endmodule

// File: doc/tqvp_crc32.md
# tqvp_crc32

Bit-serial CRC-32 (IEEE 802.3, reflected) engine exposed as a TinyQV user peripheral. It sits directly downstream of the SPI/TinyQV register harness and plugs into the slot normally taken by the example peripheral. It accepts 8/16/32-bit data writes, folds them into a running CRC at a configurable number of bits per clock, and returns the finalised CRC on read. Read completion is stalled via `data_ready` while a fold is in flight.

## Interface
- `BITS_PER_CYCLE`, default 1: data bits folded per clock; legal values 1, 2, 4, 8.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ui_in`  in  8  synchronised inputs; unused.
- `uo_out`  out  8  bit0 = busy, bit1 = done, bits 7:2 = 0.
- `address`  in  6  register byte address.
- `data_in`  in  32  write data.
- `data_write_n`  in  2  write strobe/width: 11 none, 00 byte, 01 half, 10 word.
- `data_read_n`  in  2  read strobe/width, same encoding.
- `data_out`  out  32  read data.
- `data_ready`  out  1  read data valid.
- `user_interrupt`  out  1  done & irq_en.

## Operation

**Register map.** Unmapped reads return 0; unmapped writes are ignored.
- 0x00 DATA
  - Write: load `data_in[W-1:0]` (W = 8/16/32 from `data_write_n`) into the shift register and fold LSB-first.
  - Read: `~crc` (finalised CRC).
- 0x04 CTRL
  - bit0 INIT, write 1 (self-clearing): crc = 0xFFFFFFFF, busy = 0, done = 0, overrun = 0, in-flight fold aborted.
  - bit1 IRQ_EN, R/W.
- 0x08 STATUS
  - bit0 busy (RO).
  - bit1 done, write 1 to clear.
  - bit2 overrun, write 1 to clear.
- 0x0C RAW: raw crc state, not inverted (RO).

**States.** IDLE and SHIFT.
- IDLE + DATA write: capture data and W, remaining = W/BITS_PER_CYCLE, go to SHIFT.
- SHIFT: each cycle fold BITS_PER_CYCLE bits and decrement remaining. On the last step go to IDLE and set done.
- DATA write while in SHIFT: the write is dropped and overrun is set. No stall on writes.
- Fold step, per bit: fb = crc[0] ^ d; crc = (crc >> 1) ^ (fb ? 0xEDB88320 : 0).

**Read handshake.**
- `data_ready` = 0 while `data_read_n` != 11, address is DATA or RAW, and busy = 1. Otherwise 1.
- The requester holds `address`/`data_read_n` stable until `data_ready` = 1.
- `data_out` is a combinational mux on `address`. Narrowing to the requested width is done upstream.

**Simultaneous events.**
- A CTRL.INIT write wins over a fold completing in the same cycle: done stays 0.
- A done-clear write coincident with completion leaves done = 1.

**Reset values.** crc = 0xFFFFFFFF, busy = 0, done = 0, overrun = 0, irq_en = 0, `user_interrupt` = 0, `uo_out` = 0x00, `data_ready` = 1, DATA reads 0x00000000. An `rst_n` assertion mid-fold aborts immediately.

## Timing
- A DATA write sampled at edge N gives busy = 1 from N+1 for exactly W/BITS_PER_CYCLE cycles.
- busy falls and done rises on the same edge. The final CRC is readable that cycle.
- BITS_PER_CYCLE = 1: byte 8 cycles, half 16, word 32. BITS_PER_CYCLE = 8: byte 1 cycle, word 4.
- Stalled read: `data_ready` rises combinationally in the first cycle busy = 0.
- `user_interrupt` is registered-state driven and rises the same cycle as done when irq_en = 1.
- CTRL/STATUS writes take effect at the sampling edge.

## Structure
- Package `tqvp_crc32_pkg`:
  - CRC_POLY = 32'hEDB88320, CRC_INIT = 32'hFFFFFFFF, CRC_XOROUT = 32'hFFFFFFFF.
  - Address constants ADDR_DATA/CTRL/STATUS/RAW.
  - Width-encoding constants for `data_write_n`/`data_read_n`.
  - State enum.
- One sub-module, `crc32_step`: combinational BITS_PER_CYCLE-bit fold (crc_in, data bits in, crc_out). Instantiated once. The top holds the FSM, shift register, counter and register file.

## Test plan
- Reset, then read DATA, RAW, STATUS → 0x00000000, 0xFFFFFFFF, 0x0; `uo_out` = 0x00; `data_ready` = 1.
- INIT, word write 0x34333231, word 0x38373635, byte 0x39, each waiting out busy → DATA reads 0xCBF43926 ("123456789").
- BITS_PER_CYCLE = 1, INIT, byte write 0x61, immediate DATA read → `data_ready` low for 8 cycles, then 0xE8B7BE43; done = 1.
- IRQ_EN = 1, INIT, byte 0x00 → `user_interrupt` rises with done, DATA = 0xD202EF8D. Write STATUS = 0x2 → interrupt clears.
- Word write followed by a byte write 3 cycles later → byte dropped, STATUS = 0x6 after completion, CRC equals word-only value.
- Mid-fold CTRL.INIT, and separately mid-fold `rst_n` low → busy = 0 next cycle (immediately for reset), RAW = 0xFFFFFFFF, done = 0.
